// File: rtl/fib_pkg.sv
// Shared types and constants for the two-term recurrence engine.
package fib_pkg;

   typedef enum logic [1:0] {
      MODE_FIB    = 2'b00,
      MODE_LUCAS  = 2'b01,
      MODE_CUSTOM = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int LUCAS_SEED0 = 2;
   localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_step_dp.sv
// Term registers a/b and the carry-extended adder; load seeds or advance one step.
module fib_step_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] load_a,
   input  logic [WIDTH-1:0] load_b,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             carry
);

   logic [WIDTH:0] sum;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign carry = sum[WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         a <= '0;
         b <= '0;
      end else if (load) begin
         a <= load_a;
         b <= load_b;
      end else if (step) begin
         a <= b;
         b <= sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fib_seq_engine.sv
// Multi-cycle T(k) = T(k-1) + T(k-2) engine with valid/ready request and result,
// sticky overflow and abort. One request per n+3 cycles at best.
module fib_seq_engine
   import fib_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [IDX_W-1:0] idx,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed0,
   input  logic [WIDTH-1:0] seed1,
   input  logic             abort,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]       state;
   logic [IDX_W-1:0] cnt;
   logic             ovf;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] load_a;
   logic [WIDTH-1:0] load_b;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry;
   logic             load;
   logic             step;

   // Reserved mode encoding falls back to Fibonacci seeds.
   always_comb begin
      load_a = '0;
      load_b = WIDTH'(1);
      case (mode_e'(mode))
         MODE_LUCAS: begin
            load_a = WIDTH'(LUCAS_SEED0);
            load_b = WIDTH'(LUCAS_SEED1);
         end
         MODE_CUSTOM: begin
            load_a = seed0;
            load_b = seed1;
         end
         default: begin
            load_a = '0;
            load_b = WIDTH'(1);
         end
      endcase
   end

   assign load = (state == ST_IDLE) && start_valid;
   assign step = (state == ST_RUN) && !abort && (cnt != '0);

   fib_step_dp #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .load_a (load_a),
      .load_b (load_b),
      .a      (a),
      .b      (b),
      .carry  (carry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ovf   <= 1'b0;
         res_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  cnt   <= idx;
                  ovf   <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  res_q <= a;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - IDX_W'(1);
                  // The final step's carry belongs to T(n+1), not the answer.
                  if ((cnt >= IDX_W'(2)) && carry)
                     ovf <= 1'b1;
               end
            end
            ST_DONE: begin
               if (abort || result_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign start_ready  = (state == ST_IDLE);
   assign result_valid = (state == ST_DONE);
   assign busy         = (state != ST_IDLE);
   assign result       = res_q;
   assign overflow     = ovf;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench for fib_seq_engine: 32-bit instance (directed + random) and 8-bit overflow instance.
module tb_fib_seq_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        a_start_valid, a_start_ready, a_abort, a_result_valid, a_result_ready;
   logic        a_overflow, a_busy;
   logic [5:0]  a_idx;
   logic [1:0]  a_mode;
   logic [31:0] a_seed0, a_seed1, a_result;

   logic        b_start_valid, b_start_ready, b_abort, b_result_valid, b_result_ready;
   logic        b_overflow, b_busy;
   logic [5:0]  b_idx;
   logic [1:0]  b_mode;
   logic [7:0]  b_seed0, b_seed1, b_result;

   fib_seq_engine #(.WIDTH(32), .IDX_W(6)) dut_a (
      .clk(clk), .reset(reset), .start_valid(a_start_valid), .start_ready(a_start_ready),
      .idx(a_idx), .mode(a_mode), .seed0(a_seed0), .seed1(a_seed1), .abort(a_abort),
      .result_valid(a_result_valid), .result_ready(a_result_ready), .result(a_result),
      .overflow(a_overflow), .busy(a_busy)
   );

   fib_seq_engine #(.WIDTH(8), .IDX_W(6)) dut_b (
      .clk(clk), .reset(reset), .start_valid(b_start_valid), .start_ready(b_start_ready),
      .idx(b_idx), .mode(b_mode), .seed0(b_seed0), .seed1(b_seed1), .abort(b_abort),
      .result_valid(b_result_valid), .result_ready(b_result_ready), .result(b_result),
      .overflow(b_overflow), .busy(b_busy)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   function automatic exp_t mk(input logic [31:0] r, input logic o);
      exp_t e;
      e.res = r;
      e.ovf = o;
      return e;
   endfunction

   // Exact (unbounded for our ranges) value of T(n) from the seed rules.
   function automatic logic [127:0] true_term(input int n, input logic [1:0] m,
                                              input logic [127:0] s0, input logic [127:0] s1);
      logic [127:0] t0, t1, t2;
      case (m)
         2'b01:   begin t0 = 128'd2; t1 = 128'd1; end
         2'b10:   begin t0 = s0;     t1 = s1;     end
         default: begin t0 = 128'd0; t1 = 128'd1; end
      endcase
      if (n == 0) return t0;
      for (int k = 2; k <= n; k++) begin
         t2 = t0 + t1;
         t0 = t1;
         t1 = t2;
      end
      return t1;
   endfunction

   function automatic exp_t model(input int w, input int n, input logic [1:0] m,
                                  input logic [31:0] s0, input logic [31:0] s1);
      logic [127:0] mask, t;
      mask = (128'd1 << w) - 128'd1;
      t    = true_term(n, m, {96'd0, s0} & mask, {96'd0, s1} & mask);
      return mk(32'(t & mask), (t >> w) != 128'd0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic mon_a();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && !a_abort && a_result_valid && a_result_ready) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_result: got %0h with no request outstanding", a_result);
            end else begin
               e = qa.pop_front();
               chk("a_result", {32'd0, a_result}, {32'd0, e.res});
               chk("a_overflow", {63'd0, a_overflow}, {63'd0, e.ovf});
            end
         end
      end
   endtask

   task automatic mon_b();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && b_result_valid && b_result_ready) begin
            if (qb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_result: got %0h with no request outstanding", b_result);
            end else begin
               e = qb.pop_front();
               chk("b_result", {56'd0, b_result}, {56'd0, e.res[7:0]});
               chk("b_overflow", {63'd0, b_overflow}, {63'd0, e.ovf});
            end
         end
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue_a(input int n, input logic [1:0] m, input logic [31:0] s0,
                          input logic [31:0] s1, input bit push, input exp_t e, input bit ab);
      bit got;
      got           = 1'b0;
      a_idx         = 6'(n);
      a_mode        = m;
      a_seed0       = s0;
      a_seed1       = s1;
      a_abort       = ab;
      a_start_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (a_start_ready) begin
            got = 1'b1;
            if (push) qa.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      a_start_valid = 1'b0;
      a_abort       = 1'b0;
      chk("a_request_accepted", {63'd0, got}, 64'd1);
   endtask

   task automatic wait_valid_a();
      int i;
      i = 0;
      while (!a_result_valid && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("a_result_valid_seen", {63'd0, a_result_valid}, 64'd1);
   endtask

   task automatic wait_done_a(input bit rnd);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         a_result_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         done = a_result_valid && a_result_ready;
         @(posedge clk);
         #1;
      end
      a_result_ready = 1'b1;
      chk("a_result_handshake", {63'd0, done}, 64'd1);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_start_ready"},  {63'd0, a_start_ready},  64'd1);
      chk({tag, "_result_valid"}, {63'd0, a_result_valid}, 64'd0);
      chk({tag, "_result"},       {32'd0, a_result},       64'd0);
      chk({tag, "_overflow"},     {63'd0, a_overflow},     64'd0);
      chk({tag, "_busy"},         {63'd0, a_busy},         64'd0);
   endtask

   task automatic run_b(input int n, input exp_t e);
      int i;
      b_idx         = 6'(n);
      b_start_valid = 1'b1;
      @(negedge clk);
      chk("b_start_ready", {63'd0, b_start_ready}, 64'd1);
      qb.push_back(e);
      @(posedge clk);
      #1;
      b_start_valid = 1'b0;
      i = 0;
      while (!b_result_valid && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("b_result_valid_seen", {63'd0, b_result_valid}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   int          d_n  [6] = '{10, 5, 3, 0, 1, 7};
   logic [1:0]  d_m  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3};
   logic [31:0] d_s0 [6] = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0};
   logic [31:0] d_s1 [6] = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0};
   logic [31:0] d_r  [6] = '{32'd55, 32'd11, 32'd11, 32'd0, 32'd1, 32'd13};

   initial begin
      int k;
      bit seen;
      logic [31:0] held_r;
      logic        held_o;
      int          rn;
      logic [1:0]  rm;
      logic [31:0] rs0, rs1;

      reset = 1'b1;
      a_start_valid = 1'b0; a_idx = '0; a_mode = '0; a_seed0 = '0; a_seed1 = '0;
      a_abort = 1'b0; a_result_ready = 1'b1;
      b_start_valid = 1'b0; b_idx = '0; b_mode = 2'b00; b_seed0 = '0; b_seed1 = '0;
      b_abort = 1'b0; b_result_ready = 1'b1;

      fork
         mon_a();
         mon_b();
      join_none

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_a("reset");

      // Directed cases: latency n+2 edges counting the accept, busy clears one edge later.
      for (int t = 0; t < 6; t++) begin
         issue_a(d_n[t], d_m[t], d_s0[t], d_s1[t], 1'b1, mk(d_r[t], 1'b0), 1'b0);
         k = 1;
         while (!a_result_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
         end
         chk("latency", 64'(k), 64'(d_n[t] + 2));
         @(posedge clk);
         #1;
         chk("busy_after_accept", {63'd0, a_busy}, 64'd0);
      end

      // 8-bit instance: largest non-wrapping term, then the first wrapped one.
      run_b(13, mk(32'd233, 1'b0));
      run_b(14, mk(32'd121, 1'b1));

      // Backpressure in DONE with a competing request held on the start port.
      a_result_ready = 1'b0;
      issue_a(6, 2'd0, 32'd0, 32'd0, 1'b1, mk(32'd8, 1'b0), 1'b0);
      wait_valid_a();
      held_r = a_result;
      held_o = a_overflow;
      a_idx = 6'd4; a_mode = 2'd1; a_start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_result_valid", {63'd0, a_result_valid}, 64'd1);
         chk("bp_start_ready", {63'd0, a_start_ready}, 64'd0);
         chk("bp_result_stable", {32'd0, a_result}, {32'd0, held_r});
         chk("bp_overflow_stable", {63'd0, a_overflow}, {63'd0, held_o});
      end
      a_result_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_start_ready", {63'd0, a_start_ready}, 64'd1);
      chk("bp_idle_result_valid", {63'd0, a_result_valid}, 64'd0);
      qa.push_back(mk(32'd7, 1'b0));
      @(posedge clk);
      #1;
      a_start_valid = 1'b0;
      chk("bp_next_accepted", {63'd0, a_busy}, 64'd1);
      wait_done_a(1'b0);

      // Abort in RUN when cnt has counted down to 3.
      issue_a(10, 2'd0, 32'd0, 32'd0, 1'b0, mk(32'd0, 1'b0), 1'b0);
      repeat (7) @(posedge clk);
      #1;
      a_abort = 1'b1;
      @(posedge clk);
      #1;
      a_abort = 1'b0;
      chk("abort_run_busy", {63'd0, a_busy}, 64'd0);
      chk("abort_run_start_ready", {63'd0, a_start_ready}, 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (a_result_valid) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("abort_no_result_pulse", {63'd0, seen}, 64'd0);
      issue_a(7, 2'd0, 32'd0, 32'd0, 1'b1, mk(32'd13, 1'b0), 1'b0);
      wait_done_a(1'b0);

      // Abort in DONE, then abort together with a request in IDLE.
      a_result_ready = 1'b0;
      issue_a(4, 2'd0, 32'd0, 32'd0, 1'b0, mk(32'd0, 1'b0), 1'b0);
      wait_valid_a();
      a_abort = 1'b1;
      @(posedge clk);
      #1;
      a_abort = 1'b0;
      chk("abort_done_result_valid", {63'd0, a_result_valid}, 64'd0);
      a_result_ready = 1'b1;
      issue_a(5, 2'd1, 32'd0, 32'd0, 1'b1, mk(32'd11, 1'b0), 1'b1);
      wait_done_a(1'b0);

      // Reset mid-RUN and again in DONE.
      issue_a(20, 2'd0, 32'd0, 32'd0, 1'b0, mk(32'd0, 1'b0), 1'b0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_reset_a("reset_run");
      a_result_ready = 1'b0;
      issue_a(9, 2'd0, 32'd0, 32'd0, 1'b0, mk(32'd0, 1'b0), 1'b0);
      wait_valid_a();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_reset_a("reset_done");
      a_result_ready = 1'b1;
      issue_a(12, 2'd0, 32'd0, 32'd0, 1'b1, mk(32'd144, 1'b0), 1'b0);
      wait_done_a(1'b0);

      // Random requests against the exact-arithmetic model, random consumer stalls.
      for (int t = 0; t < 25; t++) begin
         rn  = $urandom_range(0, 63);
         rm  = 2'($urandom_range(0, 3));
         rs0 = $urandom;
         rs1 = $urandom;
         if (t % 5 == 0) begin
            rs0 = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            rs1 = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            rn  = $urandom_range(0, 3);
            rm  = 2'd2;
         end
         issue_a(rn, rm, rs0, rs1, 1'b1, model(32, rn, rm, rs0, rs1), 1'b0);
         wait_done_a(1'b1);
      end

      repeat (3) @(posedge clk);
      chk("a_queue_drained", 64'(qa.size()), 64'd0);
      chk("b_queue_drained", 64'(qb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
